// File: rtl/mux2_bus_arbiter.sv
// Two-requester arbiter feeding a single registered output word and the 2:1 mux select.
// Define MUX2_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mux2_bus_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] in0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic space;
    logic last;

    assign space = !valid || ready;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (space && !rst) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
            if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
`else
            // On a tie, favour whichever requester was not granted last.
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            s     <= 1'b0;
            valid <= 1'b0;
            last  <= 1'b1;
            cnt0  <= '0;
            cnt1  <= '0;
        end else if (gnt0 || gnt1) begin
            out   <= gnt1 ? in1 : in0;
            s     <= gnt1;
            valid <= 1'b1;
            last  <= gnt1;
            if (gnt1) begin
                cnt1 <= cnt1 + 1'b1;
            end else begin
                cnt0 <= cnt0 + 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// Directed bench for mux2_bus_arbiter with a reference model and a queue of expected words.
module tb_mux2_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic [15:0] in0 = '0;
    logic        req1 = 1'b0;
    logic [15:0] in1 = '0;
    logic        gnt0, gnt1, s, valid;
    logic        ready = 1'b0;
    logic [15:0] out;
    logic [7:0]  cnt0, cnt1;

    int total = 0;
    int bad = 0;

    logic [16:0] sb[$];
    logic        m_last = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_s = 1'b0;
    logic [15:0] m_out = '0;
    logic [7:0]  m_cnt0 = '0;
    logic [7:0]  m_cnt1 = '0;

    mux2_bus_arbiter #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .in0(in0), .req1(req1), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1), .s(s), .out(out), .valid(valid), .ready(ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".out"},   32'(out),   32'(m_out));
        check({tag, ".s"},     32'(s),     32'(m_s));
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".cnt0"},  32'(cnt0),  32'(m_cnt0));
        check({tag, ".cnt1"},  32'(cnt1),  32'(m_cnt1));
    endtask

    task automatic do_reset(input int n, input logic r0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; req0 = r0; in0 = 16'hDEAD; req1 = 1'b0; ready = 1'b0;
            #1;
            check("rst.gnt0", 32'(gnt0), 32'd0);
            check("rst.gnt1", 32'(gnt1), 32'd0);
            @(posedge clk);
            #1;
            m_last = 1'b1; m_valid = 1'b0; m_s = 1'b0; m_out = '0; m_cnt0 = '0; m_cnt1 = '0;
            sb.delete();
            check_regs("rst");
        end
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0;
    endtask

    task automatic cycle(input string tag, input logic r0, input logic [15:0] d0,
                         input logic r1, input logic [15:0] d1, input logic rdy);
        logic sp, g0, g1;
        logic [16:0] w;
        @(negedge clk);
        req0 = r0; in0 = d0; req1 = r1; in1 = d1; ready = rdy;
        #1;
        sp = !m_valid || rdy;
        g0 = 1'b0;
        g1 = 1'b0;
        if (sp) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
            if (r0) g0 = 1'b1;
            else if (r1) g1 = 1'b1;
`else
            if (r0 && r1) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = r0;
                g1 = r1;
            end
`endif
        end
        check({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
        check({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
        if (g0) sb.push_back({1'b0, d0});
        if (g1) sb.push_back({1'b1, d1});
        @(posedge clk);
        #1;
        if (g0 || g1) begin
            if (sb.size() == 0) begin
                check({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                w = sb.pop_front();
                m_out = w[15:0];
                m_s = w[16];
            end
            m_valid = 1'b1;
            m_last = g1;
            if (g1) m_cnt1 = m_cnt1 + 8'd1;
            else m_cnt0 = m_cnt0 + 8'd1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        check_regs(tag);
    endtask

    initial begin
        // reset then idle
        do_reset(2, 1'b0);
        cycle("idle", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

        // single requester
        cycle("single", 1'b1, 16'h1234, 1'b0, 16'h0, 1'b1);
        check("single.out_abs", 32'(out), 32'h1234);
        cycle("drain", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

        // tie handling from a fresh reset
        do_reset(1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("tie", 1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
`ifdef MUX2_ARB_FIXED_PRIO_EN
        check("tie.last_abs", 32'(out), 32'hAAAA);
`else
        check("tie.last_abs", 32'(out), 32'h5555);
`endif

        // backpressure holds the word, then grant fires as ready rises
        for (int i = 0; i < 3; i++) cycle("bp", 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
        cycle("bp_release", 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b1);
        check("bp.out_abs", 32'(out), 32'hBEEF);
        cycle("bp_drain", 1'b0, 16'h0, 1'b1, 16'hC0DE, 1'b1);
        cycle("alone1", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

        // counter wrap on requester 0
        do_reset(1, 1'b0);
        for (int i = 0; i < 256; i++) cycle("wrap", 1'b1, 16'(i), 1'b0, 16'h0, 1'b1);
        check("wrap.cnt0_abs", 32'(cnt0), 32'd0);
        check("wrap.cnt1_abs", 32'(cnt1), 32'd0);

        // reset while a word is stalled
        cycle("stall", 1'b1, 16'h7777, 1'b0, 16'h0, 1'b0);
        do_reset(1, 1'b1);
        check("midrst.valid_abs", 32'(valid), 32'd0);
        cycle("after_rst", 1'b1, 16'h4242, 1'b1, 16'h2424, 1'b1);
        check("after_rst.s_abs", 32'(s), 32'd0);
        cycle("after_rst2", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
